trig_ddr2_line_writer: RTL
==========================

// Module: trig_ddr2_line_writer
// PURPOSE
//  Upstream feeder for the PPC440 DDR2 memory-controller MI port (16Mx32 part, 128-bit line, BL4).
//  Packs the trigger sample stream (32-bit words) into 128-bit lines and issues one MI write per line.
//  Writes go into a circular capture buffer in DDR2.
//  Double-buffered, so packing of line N+1 overlaps the outstanding MI request for line N.
// PARAMETERS
//  C_BUF_BASEADDR   32'h01000000  first byte address of ring buffer (16-byte aligned)
//  C_BUF_HIGHADDR   32'h01FFFFFF  last byte address of ring buffer (BASE..HIGH+1 multiple of 16)
//  C_CNT_WIDTH      24            width of lines_written counter
//  C_FORCE_CONFLICT 0             constant driven on mi_mcbankconflict/mi_mcrowconflict
// PORTS
//  mc_mibclk              in   1      MI clock; all logic on rising edge
//  mi_mcreset_n           in   1      async active-low reset
//  arm                    in   1      level; 1 = accept samples, 0 = stop accepting
//  flush                  in   1      pulse; write out partially filled line
//  smp_data               in   32     sample word
//  smp_valid              in   1      sample valid
//  smp_ready              out  1      sample accepted when valid&ready
//  mi_mcaddressvalid      out  1      MI write request
//  mi_mcaddress           out  [0:35] byte address; [0:3]=0, low 4 bits=0
//  mi_mcbankconflict      out  1      = C_FORCE_CONFLICT
//  mi_mcrowconflict       out  1      = C_FORCE_CONFLICT
//  mi_mcbyteenable        out  [0:15] byte enables; bit 0 = byte at lowest address
//  mi_mcwritedata         out  [0:127] line; word k in bits [32k:32k+31]
//  mi_mcreadnotwrite      out  1      constant 0
//  mi_mcwritedatavalid    out  1      asserted with mi_mcaddressvalid
//  mc_miaddrreadytoaccept in   1      controller accepts request this cycle
//  lines_written          out  C_CNT_WIDTH  lines accepted by controller, saturating
//  wrapped                out  1      sticky; ring address has wrapped at least once
//  flush_done             out  1      one-cycle pulse when flushed line is accepted
//  busy                   out  1      fill buffer non-empty or request pending
// BEHAVIOUR
//  Reset: all outputs 0.
//    Write address register = C_BUF_BASEADDR; fill count = 0; both buffers empty.
//  smp_ready = arm & ~(fill buffer full & request pending) & ~flush_pending.
//  Fill: accepted word goes to slot fill_cnt (0..3) and fill_cnt increments.
//    On the 4th word the line moves to the request register if that register is free (same edge).
//    Otherwise it waits full, and smp_ready drops until the transfer is made.
//  Request: addressvalid = writedatavalid = 1 while request register valid.
//    Address, data and byte enables stay stable until sampled with mc_miaddrreadytoaccept = 1.
//    Next request can start the cycle after acceptance; no bubble is needed.
//    Back-to-back acceptance gives 1 line/clk throughput.
//  Address: on acceptance, addr += 16.
//    If addr == C_BUF_HIGHADDR-15, addr <= C_BUF_BASEADDR and wrapped <= 1.
//  Flush: sets flush_pending.
//    If fill_cnt = 0 and nothing pending, flush_done pulses on the next cycle; no MI write.
//    Otherwise the partial line moves to the request register with byteenable = 4'hF per filled word, 0 otherwise.
//    Unfilled data bits = 0. flush_done pulses on its acceptance; flush_pending then clears.
//    Address still advances by a full 16.
//  Full line byteenable = 16'hFFFF.
//  Simultaneous smp accept of the 4th word + acceptance of the pending request: the line moves the same cycle.
//  Flush in the same cycle as a sample accept: the sample is included in the flushed line.
//  arm dropping mid-line: the partial line is held until flush or re-arm; no data is lost.
//  lines_written increments on each acceptance and saturates at all-ones.
//  Async reset mid-request drops addressvalid immediately. The controller is reset with the same reset.
//  States: IDLE (empty), FILL (0<fill_cnt<4), FULL_WAIT, and an independent REQ flag (request pending).
// STRUCTURE
//  Shared package trig_ddr2_pkg: MI_LINE_BYTES=16, MI_ADDR_W=36, MI_DATA_W=128, MI_BE_W=16, word_be() function.
//  One sub-module: trig_ddr2_line_packer (32->128 fill buffer, fill_cnt, partial-line byte-enable gen).
//  The top holds the request register, ring address, counters and flush control.
// TESTING
//  1. Arm, 8 words 0x00000001..8, ready always 1.
//     -> 2 writes at 0x01000000 / 0x01000010; data1 = 0x00000001_00000002_00000003_00000004; BE FFFF.
//  2. Ready held 0 for 20 cycles while 12 words offered.
//     -> smp_ready drops after 8 words; request fields stable; all 12 words arrive in order.
//  3. 5 words then flush.
//     -> 2nd write has BE 16'hF000 and data word0 = 5, rest 0; flush_done pulses once.
//  4. HIGHADDR = BASE+0x3F, 5 full lines.
//     -> addresses BASE, +0x10, +0x20, +0x30, BASE; wrapped = 1 after the 4th acceptance.
//  5. Flush with empty buffer -> no addressvalid; flush_done 1 cycle later.
//  6. Reset asserted during a pending request.
//     -> all outputs 0 asynchronously; after release the first write is at BASE with lines_written = 0.

Source files
------------

// File: rtl/trig_ddr2_pkg.sv
// Shared definitions for the trigger-sample DDR2 line writer.
// Holds the MI port geometry, the fill-buffer state encoding and the
// byte-enable helper used for full and partially filled lines.
package trig_ddr2_pkg;

    localparam int MI_LINE_BYTES  = 16;
    localparam int MI_ADDR_W      = 36;
    localparam int MI_DATA_W      = 128;
    localparam int MI_BE_W        = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_FULL_WAIT = 2'd2
    } fill_state_e;

    // Byte enables for a line holding 'cnt' words; word k owns bits [4k:4k+3].
    function automatic logic [0:MI_BE_W-1] word_be(input logic [2:0] cnt);
        logic [0:MI_BE_W-1] be;
        be = {MI_BE_W{1'b0}};
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            be[4*k +: 4] = (3'(k) < cnt) ? 4'hF : 4'h0;
        end
        return be;
    endfunction

endpackage

// File: rtl/trig_ddr2_line_packer.sv
// 32->128 fill buffer for the DDR2 line writer.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push         : a sample word is accepted this cycle
//   push_data    : the accepted word
//   pop          : the line (including this cycle's push) moves out this edge
//   full         : buffer holds 4 words and is waiting for the request register
//   merged_cnt   : word count including this cycle's push
//   merged_line  : line contents including this cycle's push, unfilled words 0
//   merged_be    : byte enables matching merged_cnt
module trig_ddr2_line_packer
    import trig_ddr2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [31:0]          push_data,
    input  logic                 pop,
    output logic                 full,
    output logic [2:0]           merged_cnt,
    output logic [0:MI_DATA_W-1] merged_line,
    output logic [0:MI_BE_W-1]   merged_be
);

    logic [31:0] word_r [WORDS_PER_LINE];
    logic [2:0]  fill_cnt_r;
    logic [2:0]  cnt_next_s;
    logic        push_ok_s;
    fill_state_e state_r;
    fill_state_e state_s;

    // Merge the incoming word into the current line so a line can leave on the same edge.
    always_comb begin
        push_ok_s  = push && (fill_cnt_r != 3'd4);
        merged_cnt = fill_cnt_r + {2'b00, push_ok_s};
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            merged_line[32*k +: 32] = (push_ok_s && (fill_cnt_r[1:0] == 2'(k))) ? push_data : word_r[k];
        end
        merged_be  = word_be(merged_cnt);
        if (pop) begin
            cnt_next_s = 3'd0;
        end else begin
            cnt_next_s = merged_cnt;
        end
    end

    // Fill-state next-state decode from the post-edge word count.
    always_comb begin
        state_s = ST_IDLE;
        case (cnt_next_s)
            3'd0:             state_s = ST_IDLE;
            3'd1, 3'd2, 3'd3: state_s = ST_FILL;
            3'd4:             state_s = ST_FULL_WAIT;
            default:          state_s = ST_IDLE;
        endcase
    end

    // Fill-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    assign full = (state_r == ST_FULL_WAIT);

    // Word storage; cleared on pop so a partial line carries zeros in unfilled slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r <= 3'd0;
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                word_r[k] <= 32'd0;
            end
        end else if (pop) begin
            fill_cnt_r <= 3'd0;
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                word_r[k] <= 32'd0;
            end
        end else if (push_ok_s) begin
            word_r[fill_cnt_r[1:0]] <= push_data;
            fill_cnt_r              <= merged_cnt;
        end else begin
            fill_cnt_r <= fill_cnt_r;
        end
    end

endmodule

// File: rtl/trig_ddr2_line_writer.sv
// Packs 32-bit trigger samples into 128-bit lines and writes them through the
// PPC440 DDR2 MI port into a ring buffer. One request register sits behind the
// fill buffer so packing of the next line overlaps the outstanding request.
// Ports:
//   mc_mibclk, mi_mcreset_n : clock, async active-low reset
//   arm, flush              : accept-enable level, partial-line flush pulse
//   smp_data/valid/ready    : sample stream handshake
//   mi_mc*                  : MI write request (address, data, byte enables)
//   mc_miaddrreadytoaccept  : controller takes the request this cycle
//   lines_written, wrapped, flush_done, busy : status
module trig_ddr2_line_writer
    import trig_ddr2_pkg::*;
#(
    parameter logic [31:0] C_BUF_BASEADDR   = 32'h0100_0000,
    parameter logic [31:0] C_BUF_HIGHADDR   = 32'h01FF_FFFF,
    parameter int          C_CNT_WIDTH      = 24,
    parameter logic        C_FORCE_CONFLICT = 1'b0
) (
    input  logic                   mc_mibclk,
    input  logic                   mi_mcreset_n,
    input  logic                   arm,
    input  logic                   flush,
    input  logic [31:0]            smp_data,
    input  logic                   smp_valid,
    output logic                   smp_ready,
    output logic                   mi_mcaddressvalid,
    output logic [0:MI_ADDR_W-1]   mi_mcaddress,
    output logic                   mi_mcbankconflict,
    output logic                   mi_mcrowconflict,
    output logic [0:MI_BE_W-1]     mi_mcbyteenable,
    output logic [0:MI_DATA_W-1]   mi_mcwritedata,
    output logic                   mi_mcreadnotwrite,
    output logic                   mi_mcwritedatavalid,
    input  logic                   mc_miaddrreadytoaccept,
    output logic [C_CNT_WIDTH-1:0] lines_written,
    output logic                   wrapped,
    output logic                   flush_done,
    output logic                   busy
);

    localparam logic [31:0] ADDR_STEP = 32'(MI_LINE_BYTES);
    localparam logic [31:0] WRAP_ADDR = C_BUF_HIGHADDR - (ADDR_STEP - 32'd1);

    logic                   full_s;
    logic [2:0]             merged_cnt_s;
    logic [0:MI_DATA_W-1]   merged_line_s;
    logic [0:MI_BE_W-1]     merged_be_s;
    logic                   push_s, pop_s, accept_s, req_free_s;
    logic                   flush_active_s, done_s, req_valid_next_s;
    logic [31:0]            next_addr_s;

    logic                   req_valid_r;
    logic [0:MI_ADDR_W-1]   req_addr_r;
    logic [0:MI_DATA_W-1]   req_data_r;
    logic [0:MI_BE_W-1]     req_be_r;
    logic [31:0]            addr_r;
    logic                   wrapped_r, flush_pending_r, flush_done_r, busy_r;
    logic [C_CNT_WIDTH-1:0] lines_r;

    trig_ddr2_line_packer u_packer (
        .clk         (mc_mibclk),
        .rst_n       (mi_mcreset_n),
        .push        (push_s),
        .push_data   (smp_data),
        .pop         (pop_s),
        .full        (full_s),
        .merged_cnt  (merged_cnt_s),
        .merged_line (merged_line_s),
        .merged_be   (merged_be_s)
    );

    assign smp_ready = arm & ~(full_s & req_valid_r) & ~flush_pending_r;

    // Handshake, line transfer and flush-completion decisions.
    always_comb begin
        push_s           = smp_valid & smp_ready;
        accept_s         = req_valid_r & mc_miaddrreadytoaccept;
        req_free_s       = ~req_valid_r | accept_s;
        flush_active_s   = flush | flush_pending_r;
        // A full line, or any non-empty line under flush, moves when the request slot frees.
        pop_s            = req_free_s & ((merged_cnt_s == 3'd4) |
                                         (flush_active_s & (merged_cnt_s != 3'd0)));
        // Flush completes once nothing is left to pack and the last request is leaving.
        done_s           = flush_active_s & (merged_cnt_s == 3'd0) & req_free_s;
        req_valid_next_s = pop_s | (req_valid_r & ~accept_s);
        if (addr_r == WRAP_ADDR) begin
            next_addr_s = C_BUF_BASEADDR;
        end else begin
            next_addr_s = addr_r + ADDR_STEP;
        end
    end

    // Request register; a line loaded on an acceptance edge already uses the advanced address.
    always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
        if (!mi_mcreset_n) begin
            req_valid_r <= 1'b0;
            req_addr_r  <= {MI_ADDR_W{1'b0}};
            req_data_r  <= {MI_DATA_W{1'b0}};
            req_be_r    <= {MI_BE_W{1'b0}};
        end else if (pop_s) begin
            req_valid_r <= 1'b1;
            req_addr_r  <= {4'h0, (accept_s ? next_addr_s : addr_r)};
            req_data_r  <= merged_line_s;
            req_be_r    <= merged_be_s;
        end else if (accept_s) begin
            req_valid_r <= 1'b0;
        end else begin
            req_valid_r <= req_valid_r;
        end
    end

    // Ring address, wrap flag and saturating line counter advance on acceptance.
    always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
        if (!mi_mcreset_n) begin
            addr_r    <= C_BUF_BASEADDR;
            wrapped_r <= 1'b0;
            lines_r   <= {C_CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            addr_r <= next_addr_s;
            if (addr_r == WRAP_ADDR) begin
                wrapped_r <= 1'b1;
            end
            if (lines_r != {C_CNT_WIDTH{1'b1}}) begin
                lines_r <= lines_r + C_CNT_WIDTH'(1);
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    // Flush tracking and registered status outputs.
    always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
        if (!mi_mcreset_n) begin
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            flush_pending_r <= flush_active_s & ~done_s;
            flush_done_r    <= done_s;
            busy_r          <= (~pop_s & (merged_cnt_s != 3'd0)) | req_valid_next_s;
        end
    end

    assign mi_mcaddressvalid   = req_valid_r;
    assign mi_mcwritedatavalid = req_valid_r;
    assign mi_mcaddress        = req_addr_r;
    assign mi_mcwritedata      = req_data_r;
    assign mi_mcbyteenable     = req_be_r;
    assign mi_mcreadnotwrite   = 1'b0;
    assign mi_mcbankconflict   = C_FORCE_CONFLICT;
    assign mi_mcrowconflict    = C_FORCE_CONFLICT;
    assign lines_written       = lines_r;
    assign wrapped             = wrapped_r;
    assign flush_done          = flush_done_r;
    assign busy                = busy_r;

endmodule
